agu_issue_arbiter: RTL and testbench



---
 rtl/agu_issue_arbiter.sv | 131 +++++++++++++
 tb/tb_agu_issue_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/agu_issue_arbiter.sv
// Round-robin arbiter sharing the AGU0 issue slot between the memory issue queue (req0)
// and the replay/CMO queue (req1). Define AGU_ARB_PERF_EN to build the performance counters.
module agu_issue_arbiter #(
    parameter int ROB_W  = 6,
    parameter int DEST_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_n_i,
    input  logic              flush_i,
    input  logic              req0_vld_i,
    input  logic              req1_vld_i,
    output logic              req0_rdy_o,
    output logic              req1_rdy_o,
    input  logic [ROB_W-1:0]  req0_rob_i,
    input  logic              req0_cmo_i,
    input  logic [3:0]        req0_op_i,
    input  logic [DATA_W-1:0] req0_rs1_i,
    input  logic [DATA_W-1:0] req0_rs2_i,
    input  logic [DATA_W-1:0] req0_imm_i,
    input  logic [DEST_W-1:0] req0_dest_i,
    input  logic [ROB_W-1:0]  req1_rob_i,
    input  logic              req1_cmo_i,
    input  logic [3:0]        req1_op_i,
    input  logic [DATA_W-1:0] req1_rs1_i,
    input  logic [DATA_W-1:0] req1_rs2_i,
    input  logic [DATA_W-1:0] req1_imm_i,
    input  logic [DEST_W-1:0] req1_dest_i,
    output logic              agu_vld_o,
    output logic [ROB_W-1:0]  agu_rob_o,
    output logic              agu_cmo_o,
    output logic [3:0]        agu_op_o,
    output logic [DATA_W-1:0] agu_rs1_o,
    output logic [DATA_W-1:0] agu_rs2_o,
    output logic [DATA_W-1:0] agu_imm_o,
    output logic [DEST_W-1:0] agu_dest_o,
    input  logic              agu_busy_i,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_stall_o
);

    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic              cmo;
        logic [3:0]        op;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
        logic [DEST_W-1:0] dest;
    } uop_t;

    uop_t req0_uop, req1_uop, sel_uop, slot_q;
    logic vld_q;
    logic rr_ptr;
    logic slot_free;
    logic grant0, grant1;

    assign req0_uop = '{rob: req0_rob_i, cmo: req0_cmo_i, op: req0_op_i, rs1: req0_rs1_i,
                        rs2: req0_rs2_i, imm: req0_imm_i, dest: req0_dest_i};
    assign req1_uop = '{rob: req1_rob_i, cmo: req1_cmo_i, op: req1_op_i, rs1: req1_rs1_i,
                        rs2: req1_rs2_i, imm: req1_imm_i, dest: req1_dest_i};

    assign slot_free = !vld_q || !agu_busy_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!flush_i && slot_free && cpu_reset_n_i) begin
            grant0 = req0_vld_i && (!req1_vld_i || !rr_ptr);
            grant1 = req1_vld_i && (!req0_vld_i ||  rr_ptr);
        end
    end

    assign sel_uop    = grant1 ? req1_uop : req0_uop;
    assign req0_rdy_o = grant0;
    assign req1_rdy_o = grant1;

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            vld_q  <= 1'b0;
            rr_ptr <= 1'b0;
            slot_q <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (grant0 || grant1) begin
            vld_q  <= 1'b1;
            slot_q <= sel_uop;
            rr_ptr <= grant0;  // aim at the requester that just lost its turn
        end else if (vld_q && !agu_busy_i) begin
            vld_q <= 1'b0;
        end
    end

    assign agu_vld_o  = vld_q;
    assign agu_rob_o  = slot_q.rob;
    assign agu_cmo_o  = slot_q.cmo;
    assign agu_op_o   = slot_q.op;
    assign agu_rs1_o  = slot_q.rs1;
    assign agu_rs2_o  = slot_q.rs2;
    assign agu_imm_o  = slot_q.imm;
    assign agu_dest_o = slot_q.dest;

`ifdef AGU_ARB_PERF_EN
    logic [31:0] grant0_cnt, grant1_cnt, stall_cnt;

    // Counters ignore flush; they only track grants and blocked demand.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (grant0) grant0_cnt <= grant0_cnt + 32'd1;
            if (grant1) grant1_cnt <= grant1_cnt + 32'd1;
            if ((req0_vld_i || req1_vld_i) && !slot_free) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_grant0_o = grant0_cnt;
    assign perf_grant1_o = grant1_cnt;
    assign perf_stall_o  = stall_cnt;
`else
    assign perf_grant0_o = 32'd0;
    assign perf_grant1_o = 32'd0;
    assign perf_stall_o  = 32'd0;
`endif

endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Directed self-checking bench for agu_issue_arbiter; expectations follow AGU_ARB_PERF_EN if defined.
module tb_agu_issue_arbiter;

    localparam int ROB_W  = 6;
    localparam int DEST_W = 6;
    localparam int DATA_W = 32;
`ifdef AGU_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic flush, busy;
    logic req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [ROB_W-1:0]  req0_rob, req1_rob, agu_rob;
    logic              req0_cmo, req1_cmo, agu_cmo;
    logic [3:0]        req0_op, req1_op, agu_op;
    logic [DATA_W-1:0] req0_rs1, req0_rs2, req0_imm, req1_rs1, req1_rs2, req1_imm;
    logic [DATA_W-1:0] agu_rs1, agu_rs2, agu_imm;
    logic [DEST_W-1:0] req0_dest, req1_dest, agu_dest;
    logic              agu_vld;
    logic [31:0]       perf_g0, perf_g1, perf_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agu_issue_arbiter #(.ROB_W(ROB_W), .DEST_W(DEST_W), .DATA_W(DATA_W)) dut (
        .cpu_clock_i(clk), .cpu_reset_n_i(rst_n), .flush_i(flush),
        .req0_vld_i(req0_vld), .req1_vld_i(req1_vld),
        .req0_rdy_o(req0_rdy), .req1_rdy_o(req1_rdy),
        .req0_rob_i(req0_rob), .req0_cmo_i(req0_cmo), .req0_op_i(req0_op),
        .req0_rs1_i(req0_rs1), .req0_rs2_i(req0_rs2), .req0_imm_i(req0_imm), .req0_dest_i(req0_dest),
        .req1_rob_i(req1_rob), .req1_cmo_i(req1_cmo), .req1_op_i(req1_op),
        .req1_rs1_i(req1_rs1), .req1_rs2_i(req1_rs2), .req1_imm_i(req1_imm), .req1_dest_i(req1_dest),
        .agu_vld_o(agu_vld), .agu_rob_o(agu_rob), .agu_cmo_o(agu_cmo), .agu_op_o(agu_op),
        .agu_rs1_o(agu_rs1), .agu_rs2_o(agu_rs2), .agu_imm_o(agu_imm), .agu_dest_o(agu_dest),
        .agu_busy_i(busy),
        .perf_grant0_o(perf_g0), .perf_grant1_o(perf_g1), .perf_stall_o(perf_st)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, "_rdy0"}, req0_rdy, r0);
        check({tag, "_rdy1"}, req1_rdy, r1);
    endtask

    task automatic check_perf(input string tag, input int g0, input int g1, input int st);
        check({tag, "_g0"}, perf_g0, PERF ? g0 : 0);
        check({tag, "_g1"}, perf_g1, PERF ? g1 : 0);
        check({tag, "_st"}, perf_st, PERF ? st : 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; busy = 1'b0;
        req0_vld = 1'b1; req1_vld = 1'b0;
        req0_rob = 6'd5; req0_cmo = 1'b0; req0_op = 4'b1010;
        req0_rs1 = 32'h1000_0000; req0_rs2 = 32'h0000_00AA; req0_imm = 32'h10; req0_dest = 6'd3;
        req1_rob = 6'd7; req1_cmo = 1'b1; req1_op = 4'b0001;
        req1_rs1 = 32'h2000_0000; req1_rs2 = 32'h0000_00BB; req1_imm = 32'h20; req1_dest = 6'd9;

        // Reset state: outputs zero, no rdy even with a pending request.
        #3;
        check("rst_vld", agu_vld, 0);
        check_rdy("rst", 1'b0, 1'b0);
        step();
        check("rst_vld_edge", agu_vld, 0);
        check("rst_rob", agu_rob, 0);
        check("rst_op", agu_op, 0);
        check_perf("rst", 0, 0, 0);
        #2 rst_n = 1'b1;
        step();
        // First edge after release already granted req0 (rdy was high from t=8).
        check("single0_vld", agu_vld, 1);
        check("single0_rob", agu_rob, 5);
        check("single0_op", agu_op, 4'b1010);
        check("single0_dest", agu_dest, 3);
        check("single0_rs1", agu_rs1, 32'h1000_0000);

        // Single requester on req1 -> grant, pointer returns to req0.
        req0_vld = 1'b0; req1_vld = 1'b1;
        #1 check_rdy("single1", 1'b0, 1'b1);
        step();
        check("single1_rob", agu_rob, 7);
        check("single1_cmo", agu_cmo, 1);
        check("single1_imm", agu_imm, 32'h20);

        // Consume with no new grant drops valid.
        req1_vld = 1'b0;
        step();
        check("idle_vld", agu_vld, 0);

        // Both valid, never busy: 0,1,0,1 with valid held high.
        req0_rob = 6'd10; req1_rob = 6'd20;
        req0_vld = 1'b1; req1_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            step();
            check($sformatf("rr%0d_vld", i), agu_vld, 1);
            check($sformatf("rr%0d_rob", i), agu_rob, (i % 2) == 0 ? 10 : 20);
        end

        // Busy hold: payload stable, no rdy for 3 cycles.
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_rdy($sformatf("hold%0d", i), 1'b0, 1'b0);
            step();
            check($sformatf("hold%0d_vld", i), agu_vld, 1);
            check($sformatf("hold%0d_rob", i), agu_rob, 20);
        end
        busy = 1'b0;
        #1 check_rdy("unhold", 1'b1, 1'b0);
        step();
        check("unhold_rob", agu_rob, 10);

        // Flush while busy: valid drops, no grant, pointer stays on req1.
        busy = 1'b1; flush = 1'b1;
        #1 check_rdy("flush", 1'b0, 1'b0);
        step();
        check("flush_vld", agu_vld, 0);
        flush = 1'b0; busy = 1'b0;
        #1 check_rdy("postflush", 1'b0, 1'b1);
        step();
        check("postflush_rob", agu_rob, 20);
        check("postflush_vld", agu_vld, 1);

        // req0 alone aims the pointer at req1 before the reset test.
        req1_vld = 1'b0;
        step();
        check("pre_rst_rob", agu_rob, 10);
        check_perf("perf", 5, 4, 4);

        // Asynchronous reset mid-cycle with a valid uop in the slot.
        req1_vld = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("arst_vld", agu_vld, 0);
        check_rdy("arst", 1'b0, 1'b0);
        check_perf("arst", 0, 0, 0);
        #1 rst_n = 1'b1;
        #1 check_rdy("after_rst", 1'b1, 1'b0);
        step();
        check("after_rst_rob", agu_rob, 10);
        check("after_rst_vld", agu_vld, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
